// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, fill FSM states and element type for matrix_tile_loader
package matrix_pkg;
  localparam int N_DEFAULT = 3;
  localparam int DATA_WIDTH_DEFAULT = 8;
  typedef enum logic [1:0] {FILLING, COMPLETE, SHOWING} fill_state_e;
  typedef logic [DATA_WIDTH_DEFAULT-1:0] elem_t;
endpackage

// File: rtl/matrix_tile_bank.sv
// matrix_tile_bank: N x N element store with valid bits; write port, tail clear, full clear and parallel load
module matrix_tile_bank
  import matrix_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [$clog2(N)-1:0]                wr_row,
  input  logic [$clog2(N)-1:0]                wr_col,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic                                clr_tail,
  input  logic                                clr_all,
  input  logic                                load_en,
  input  logic [0:N-1][0:N-1][DATA_WIDTH-1:0] load_data,
  input  logic [0:N-1][0:N-1]                 load_valid,
  output logic [0:N-1][0:N-1][DATA_WIDTH-1:0] data,
  output logic [0:N-1][0:N-1]                 valid
);
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0] data_q, data_d;
  logic [0:N-1][0:N-1]                 valid_q, valid_d;

  // tail clear wipes every position after the write pointer, so a short tile is zero-padded
  always_comb begin
    data_d = data_q;
    valid_d = valid_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (clr_all) begin
          data_d[i][j] = '0;
          valid_d[i][j] = 1'b0;
        end else if (load_en) begin
          data_d[i][j] = load_data[i][j];
          valid_d[i][j] = load_valid[i][j];
        end else begin
          if (wr_en && i == int'(wr_row) && j == int'(wr_col)) begin
            data_d[i][j] = wr_data;
            valid_d[i][j] = 1'b1;
          end
          if (clr_tail && (i * N + j) > (int'(wr_row) * N + int'(wr_col))) begin
            data_d[i][j] = '0;
            valid_d[i][j] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      valid_q <= '0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/matrix_tile_loader.sv
// matrix_tile_loader: assembles a row-major element stream into N x N tiles shown one per phase frame.
// MATRIX_TILE_LOADER_DBUF_EN selects separate fill/display banks; default is a single shared bank.
module matrix_tile_loader
  import matrix_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  input  logic                                s_last,
  input  logic                                s_row_sel,
  output logic [0:N-1][0:N-1][DATA_WIDTH-1:0] matrix,
  output logic [0:N-1][0:N-1]                 valid_bits_out,
  output logic                                row_sel,
  output logic [$clog2(N)-1:0]                phase,
  output logic                                frame_start
);
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_PH = PW'(N - 1);

  fill_state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, row_q, row_d, col_q, col_d;
  logic s_ready_q, s_ready_d, fill_rs_q, fill_rs_d, frame_start_q, frame_start_d;
  logic accept, tile_done, frame_end, xfer;
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0] fill_data;
  logic [0:N-1][0:N-1]                 fill_valid;

  assign accept = s_valid & s_ready_q;
  assign tile_done = accept & (s_last | (row_q == LAST_PH && col_q == LAST_PH));
  assign frame_end = phase_q == LAST_PH;
  // a tile completed in a phase N-1 cycle is still FILLING here, so it waits a full frame
  assign xfer = frame_end && state_q == COMPLETE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILLING;
      phase_q <= '0;
      row_q <= '0;
      col_q <= '0;
      s_ready_q <= 1'b0;
      fill_rs_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      row_q <= row_d;
      col_q <= col_d;
      s_ready_q <= s_ready_d;
      fill_rs_q <= fill_rs_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILLING:  state_d = tile_done ? COMPLETE : FILLING;
`ifdef MATRIX_TILE_LOADER_DBUF_EN
      COMPLETE: state_d = xfer ? FILLING : COMPLETE;
`else
      COMPLETE: state_d = xfer ? SHOWING : COMPLETE;
`endif
      SHOWING:  state_d = frame_end ? FILLING : SHOWING;
      default:  state_d = FILLING;
    endcase
  end

  always_comb begin
    phase_d = frame_end ? '0 : phase_q + 1'b1;
    row_d = tile_done ? '0 : (accept && col_q == LAST_PH) ? row_q + 1'b1 : row_q;
    col_d = tile_done ? '0 : accept ? (col_q == LAST_PH ? '0 : col_q + 1'b1) : col_q;
    s_ready_d = state_d == FILLING;
    fill_rs_d = (accept && row_q == '0 && col_q == '0) ? s_row_sel : fill_rs_q;
    frame_start_d = xfer;
  end

  assign s_ready = s_ready_q;
  assign phase = phase_q;
  assign frame_start = frame_start_q;

`ifdef MATRIX_TILE_LOADER_DBUF_EN
  logic disp_rs_q, disp_rs_d;
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0] disp_data;
  logic [0:N-1][0:N-1]                 disp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_rs_q <= 1'b0;
    else disp_rs_q <= disp_rs_d;
  end

  always_comb disp_rs_d = xfer ? fill_rs_q : frame_end ? 1'b0 : disp_rs_q;

  matrix_tile_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_fill (
    .clk, .rst_n, .wr_en(accept), .wr_row(row_q), .wr_col(col_q), .wr_data(s_data),
    .clr_tail(accept & s_last), .clr_all(xfer), .load_en(1'b0), .load_data('0), .load_valid('0),
    .data(fill_data), .valid(fill_valid)
  );

  matrix_tile_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_disp (
    .clk, .rst_n, .wr_en(1'b0), .wr_row('0), .wr_col('0), .wr_data('0),
    .clr_tail(1'b0), .clr_all(frame_end & ~xfer), .load_en(xfer), .load_data(fill_data),
    .load_valid(fill_valid), .data(disp_data), .valid(disp_valid)
  );

  assign matrix = disp_data;
  assign valid_bits_out = disp_valid;
  assign row_sel = disp_rs_q;
`else
  logic showing;

  assign showing = state_q == SHOWING;

  matrix_tile_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_bank (
    .clk, .rst_n, .wr_en(accept), .wr_row(row_q), .wr_col(col_q), .wr_data(s_data),
    .clr_tail(accept & s_last), .clr_all(showing & frame_end), .load_en(1'b0), .load_data('0),
    .load_valid('0), .data(fill_data), .valid(fill_valid)
  );

  assign matrix = showing ? fill_data : '0;
  assign valid_bits_out = showing ? fill_valid : '0;
  assign row_sel = showing & fill_rs_q;
`endif
endmodule

// File: doc/matrix_tile_loader.md
# matrix_tile_loader

- Upstream stage of the skewed-row/column shifter in the systolic datapath.
- Accepts matrix elements as a row-major valid/ready stream and assembles them into an N×N tile with per-element valid bits.
- Publishes each tile for exactly one N-cycle frame, aligned to a free-running phase counter that resets together with the shifter's internal state.
- Also drives the row/column mode select for each tile.

## Interface
Parameters:
- N, 3, matrix dimension.
- DATA_WIDTH, 8, element width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input element valid.
- s_ready  out  1  input element ready; driven from registered state only.
- s_data  in  DATA_WIDTH  input element.
- s_last  in  1  last element of tile; remaining positions are padded.
- s_row_sel  in  1  mode for the tile; sampled on the tile's first accepted element.
- matrix  out  [0:N-1][0:N-1]×DATA_WIDTH  published tile.
- valid_bits_out  out  [0:N-1][0:N-1]×1  per-element valid of published tile.
- row_sel  out  1  mode of published tile.
- phase  out  $clog2(N)  frame phase, 0..N-1.
- frame_start  out  1  one-cycle pulse in the phase-0 cycle of a newly published tile.

## Operation
- Phase counter:
  - Reset value 0.
  - Increments every cycle and wraps from N-1 to 0.
  - Ignores all other activity.
- Fill bank FSM, states FILLING and COMPLETE:
  - FILLING: s_ready=1. Each accepted element is written to [r][c] with valid=1.
  - Write pointer advances c first; at c==N-1 it sets c=0 and increments r.
  - Tile completes on acceptance of element (N-1,N-1), or on an accepted element with s_last=1. The latter clears all later positions to data 0 / valid 0.
  - s_last on element (N-1,N-1) is identical to plain completion. Without s_last, the N*N-th element still completes the tile.
  - COMPLETE: s_ready=0. Leaves on the transfer edge (below), clearing the bank and pointer and returning to FILLING.
- Transfer edge:
  - The edge ending a cycle with phase==N-1 while the fill FSM is COMPLETE.
  - Copies the bank, row_sel and valid bits into the display registers.
- Display:
  - Each tile is shown for exactly one frame (phase 0..N-1).
  - At the end of a frame with no transfer, the display is cleared: matrix 0, valid_bits_out all 0, row_sel 0.
- Reset values: every output is 0, and s_ready=0 during reset. The first cycle after reset is FILLING with s_ready=1.
- Reset mid-operation discards any partial and displayed tile and restarts the phase at 0.
- Simultaneous completion and transfer edge: the element accepted in a phase==N-1 cycle completes the tile, but it is NOT transferred at that same edge. The tile waits for the next phase==N-1 edge.

## Timing
- s_ready has no combinational path from s_valid.
- Tile latency: outputs update at the first phase N-1→0 edge strictly after the completion edge. That is 2 to N+1 cycles after the last element is sampled.
- Outputs are registered and stable for the whole frame.
- Throughput with DBUF: one tile per max(N*N, N) accept cycles, rounded up to a frame boundary, plus one frame.

## Configuration
- MATRIX_TILE_LOADER_DBUF_EN defined:
  - Separate fill and display banks; filling of the next tile proceeds while the current tile is displayed.
  - s_ready drops only in COMPLETE.
- MATRIX_TILE_LOADER_DBUF_EN undefined:
  - Single bank. The fill FSM gains state SHOWING, entered at the transfer edge.
  - In SHOWING, s_ready=0 and the bank is the display.
  - SHOWING lasts one frame, then the bank clears and the FSM returns to FILLING.
  - While FILLING or COMPLETE, valid_bits_out is forced to all 0 and matrix to 0.

## Structure
- Shared package matrix_pkg holds:
  - default N and DATA_WIDTH constants;
  - the fill FSM state enum (FILLING, COMPLETE, SHOWING);
  - the element typedef.
- Sub-module matrix_tile_bank: N×N data + valid storage with write port (row, col, data), clear-tail-from-pointer, full clear and parallel load. Instantiated twice with DBUF, once without.

## Test plan
- N=3, stream 1..9 row-major with s_row_sel=1 and no gaps → at the next frame boundary, matrix[0][0]=1, [1][2]=6, [2][2]=9, all valid=1, row_sel=1, frame_start for 1 cycle. After 3 cycles, valid all 0.
- s_last with element 4 (value 0x44) → [1][0]=0x44 valid=1; [1][1]..[2][2] data 0 valid 0. The next tile starts at [0][0].
- Two back-to-back tiles with DBUF → shown on the frames following each completion. s_ready is low only during COMPLETE; no element is lost or duplicated.
- Same stimulus without DBUF → s_ready is 0 for the 3-cycle SHOWING frame, and outputs are all-invalid while the second tile fills.
- Random s_valid gaps (50%) → tile contents identical to the gap-free case. s_ready is independent of s_valid in the same cycle.
- rst_n pulsed after 5 elements → all outputs 0 and phase=0. The next 9 elements form a complete fresh tile.
